// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer; both flops reset to the idle-high line level.
module sync2_n (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-sampled frames, optional parity, held output
// register with valid/ready handshake and a sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = 4;
    localparam logic [CW-1:0] HALF   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_D = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_S = BW'(STOP_BITS - 1);
    localparam logic          ODD    = (PARITY == PAR_ODD);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 done;
    logic                 tick;
    logic                 accept;

    sync2_n u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (rx_in),
        .q       (rx_s)
    );

    assign tick   = (cnt_q == '0);
    assign accept = data_valid & data_ready;
    assign busy   = (state_q != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = HALF;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rx_s) begin
                    state_d = S_DATA;
                    cnt_d   = FULL;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FULL;
                    if (bit_q == LAST_D) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // even mode flags a 1, odd mode flags a 0
                    perr_d  = (^shift_q) ^ rx_s ^ ODD;
                    cnt_d   = FULL;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!rx_s) ferr_d = 1'b1;
                    if (bit_q == LAST_S) begin
                        done    = 1'b1;
                        state_d = rx_s ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        cnt_d = FULL;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // a completion only loads when the holding register is free or freeing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (done && (!data_valid || data_ready)) begin
                data_out   <= shift_q;
                parity_err <= perr_q;
                frame_err  <= ferr_d;
                data_valid <= 1'b1;
            end else if (accept) begin
                data_valid <= 1'b0;
            end
            if (done && data_valid && !data_ready) begin
                overrun <= 1'b1;
            end else if (accept) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
